// File: rtl/seg7_scan_driver.sv
// Six-digit (parameterisable) multiplexed 7-segment scan driver with frame-synchronous snapshot,
// blank/blink masks and optional leading-zero suppression (SEG7_LEADING_ZERO_BLANK_EN).
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int DWELL          = 1,
  parameter int BLINK_DIV      = 125,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_1khz,
  input  logic                    switch_clr,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start,
  output logic                    blink_phase
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL - 1);
  localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [DWELL_W-1:0]      dwell_reg, dwell_next;
  logic                    frame_start_reg, frame_start_next;
  logic                    reload;

  logic [4*NUM_DIGITS-1:0] snap_reg;
  logic [NUM_DIGITS-1:0]   bmask_reg;
  logic [NUM_DIGITS-1:0]   kmask_reg;
  logic [NUM_DIGITS-1:0]   lz_mask;

  logic [BLINK_W-1:0]      blink_cnt_reg;
  logic                    blink_phase_reg;

  logic [NUM_DIGITS-1:0]   dig_onehot;
  logic [NUM_DIGITS-1:0]   digit_dark;
  logic [6:0]              digit_seg [NUM_DIGITS];
  logic [6:0]              seg_lit;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    pattern = 7'b0000000;
    case (value)
      4'd0:    pattern = 7'b0111111;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
    return pattern;
  endfunction

  // Blink timebase runs regardless of scan state; it is deliberately not frame-aligned.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (blink_cnt_reg == LAST_BLINK) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= ~blink_phase_reg;
    end else begin
      blink_cnt_reg   <= blink_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      dwell_reg       <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      dwell_reg       <= dwell_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    dwell_next       = dwell_reg;
    frame_start_next = 1'b0;
    reload           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        state_next       = ST_SCAN;
        idx_next         = '0;
        dwell_next       = '0;
        frame_start_next = 1'b1;
        reload           = 1'b1;
      end
      ST_SCAN: begin
        if (dwell_reg != LAST_DWELL) begin
          dwell_next = dwell_reg + 1'b1;
        end else begin
          dwell_next = '0;
          if (idx_reg == LAST_IDX) begin
            idx_next         = '0;
            frame_start_next = 1'b1;
            reload           = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The snapshot only moves at frame boundaries, which is what keeps a frame from tearing.
  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      snap_reg  <= '0;
      bmask_reg <= '0;
      kmask_reg <= '0;
    end else if (reload) begin
      snap_reg  <= digits_in;
      bmask_reg <= blank_mask | lz_mask;
      kmask_reg <= blink_mask;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // higher_clear[gi]: every digit above gi is zero or explicitly blanked.
  logic [NUM_DIGITS-1:1] higher_clear;

  assign lz_mask[0] = 1'b0;

  generate
    for (genvar gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign higher_clear[gi] = 1'b1;
      end else begin : g_lower
        assign higher_clear[gi] = higher_clear[gi+1] &
                                  ((digits_in[4*(gi+1) +: 4] == 4'd0) | blank_mask[gi+1]);
      end
      assign lz_mask[gi] = (digits_in[4*gi +: 4] == 4'd0) & higher_clear[gi];
    end
  endgenerate
`else
  assign lz_mask = '0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign dig_onehot[gi] = (state_reg == ST_SCAN) && (idx_reg == IDX_W'(gi));
      assign digit_dark[gi] = bmask_reg[gi]
                            | (kmask_reg[gi] & ~blink_phase_reg)
                            | (snap_reg[4*gi +: 4] > 4'd9);
      assign digit_seg[gi]  = digit_dark[gi] ? 7'b0000000 : bcd_to_seg(snap_reg[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    seg_lit = 7'b0000000;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_onehot[i]) begin
        seg_lit = seg_lit | digit_seg[i];
      end
    end
  end

  generate
    if (SEG_ACTIVE_LOW) begin : g_pol_low
      assign seg_out = ~seg_lit;
      assign dig_sel = ~dig_onehot;
    end else begin : g_pol_high
      assign seg_out = seg_lit;
      assign dig_sel = dig_onehot;
    end
  endgenerate

  assign frame_start = frame_start_reg;
  assign blink_phase = blink_phase_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model predicts every output
// sample, a separate monitor compares on each falling edge.
module tb_seg7_scan_driver;

  localparam int N  = 6;
  localparam int DW = 1;
  localparam int BD = 125;
  localparam int FRAME = N * DW;

  logic             clk_1khz = 1'b0;
  logic             switch_clr;
  logic [4*N-1:0]   digits_in;
  logic [N-1:0]     blank_mask;
  logic [N-1:0]     blink_mask;
  logic [6:0]       seg_out;
  logic [N-1:0]     dig_sel;
  logic             frame_start;
  logic             blink_phase;

  always #5 clk_1khz = ~clk_1khz;

  seg7_scan_driver #(
    .NUM_DIGITS(N),
    .DWELL(DW),
    .BLINK_DIV(BD),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_1khz(clk_1khz),
    .switch_clr(switch_clr),
    .digits_in(digits_in),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .seg_out(seg_out),
    .dig_sel(dig_sel),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  typedef struct packed {
    logic [N-1:0] dig;
    logic [6:0]   seg;
    logic         fs;
    logic         bp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference model: everything derives from the number of edges since reset release.
  int           edges = 0;
  logic [4*N-1:0] m_snap = '0;
  logic [N-1:0] m_bm = '0;
  logic [N-1:0] m_km = '0;

  function automatic logic [N-1:0] leading_zero_mask(input logic [4*N-1:0] d,
                                                     input logic [N-1:0] bm);
    logic [N-1:0] m;
    m = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      bit all_above_clear;
      all_above_clear = 1'b1;
      for (int i = N - 1; i >= 1; i--) begin
        if (all_above_clear && d[4*i +: 4] == 4'd0) m[i] = 1'b1;
        all_above_clear = all_above_clear && (d[4*i +: 4] == 4'd0 || bm[i]);
      end
    end
`else
    if (d == '1 && bm == '1) m = '0;
`endif
    return m;
  endfunction

  always @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      edges <= 0;
    end else begin
      if (edges % FRAME == 0) begin
        m_snap <= digits_in;
        m_bm   <= blank_mask | leading_zero_mask(digits_in, blank_mask);
        m_km   <= blink_mask;
      end
      edges <= edges + 1;
    end
  end

  always @(negedge clk_1khz) begin
    exp_t e;
    int pos;
    int d;
    logic [3:0] v;
    logic dark;
    e = '0;
    e.bp = ((edges / BD) % 2 == 0);
    if (switch_clr && edges > 0) begin
      pos = (edges - 1) % FRAME;
      d = pos / DW;
      e.dig[d] = 1'b1;
      e.fs = (pos == 0);
      v = m_snap[4*d +: 4];
      dark = m_bm[d] | (m_km[d] & ~e.bp) | (v > 4'd9);
      e.seg = dark ? 7'd0 : seg_tab[v];
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk_1khz) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL queue_empty t=%0t got=0 want=1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("dig_sel", int'(dig_sel), int'(e.dig));
      chk("seg_out", int'(seg_out), int'(e.seg));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("blink_phase", int'(blink_phase), int'(e.bp));
    end
  end

  // Inputs change 2 time units after a rising edge, well clear of both clock edges.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_1khz);
    #2;
  endtask

  task automatic apply(input logic [4*N-1:0] d, input logic [N-1:0] bm, input logic [N-1:0] km);
    digits_in  = d;
    blank_mask = bm;
    blink_mask = km;
    $display("stim t=%0t digits=%06h blank=%b blink=%b", $time, d, bm, km);
  endtask

  initial begin
    switch_clr = 1'b0;
    apply(24'h123456, '0, '0);
    cycles(3);
    switch_clr = 1'b1;
    $display("stim t=%0t release reset", $time);
    cycles(3);
    apply(24'h999999, '0, '0);
    cycles(14);
    apply(24'h0A3456, 6'b000100, 6'b000001);
    cycles(300);
    cycles(1);
    switch_clr = 1'b0;
    $display("stim t=%0t reset mid-scan", $time);
    cycles(2);
    switch_clr = 1'b1;
    apply(24'h123456, '0, '0);
    cycles(4);
    switch_clr = 1'b0;
    $display("stim t=%0t reset at digit 3", $time);
    cycles(1);
    switch_clr = 1'b1;
    cycles(10);
    repeat (25) begin
      apply(24'($urandom), 6'($urandom) & 6'($urandom), 6'($urandom));
      cycles($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        switch_clr = 1'b0;
        $display("stim t=%0t random reset", $time);
        cycles($urandom_range(1, 3));
        switch_clr = 1'b1;
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    apply(24'h000705, '0, '0);
    cycles(14);
    apply(24'h000000, '0, '0);
    cycles(14);
`endif
    cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
